// File: rtl/fb_pkg.sv
// Shared constants, types and helpers for the frame-buffer rectangle writer.
package fb_pkg;

  // Frame geometry of the 320x240 pixel-doubled buffer.
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_PIXELS = 76800;

  typedef logic [16:0] fb_addr_t;
  typedef logic [7:0]  fb_color_t;

  // One latched rectangle-fill command.
  typedef struct packed {
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] w;
    logic [7:0] h;
    fb_color_t  color;
    logic       sync;
  } rect_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    CLIP,
    WAIT_VS,
    WRITE,
    DONE
  } wr_state_t;

  // y*320 built from two shifts (256 + 64) so no multiplier is needed.
  function automatic fb_addr_t row_base_of(input logic [7:0] y);
    fb_addr_t y_ext;
    y_ext = {9'd0, y};
    return (y_ext << 8) + (y_ext << 6);
  endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clip of a rectangle against the frame, plus the empty check.
module fb_rect_clip
  import fb_pkg::*;
#(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H
) (
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] w,
  input  logic [7:0] h,
  output logic [9:0] xe,
  output logic [9:0] ye,
  output logic       empty
);

  logic [9:0] x_end;
  logic [9:0] y_end;

  // Exclusive end coordinates, 10 bits wide so x0+w and y0+h cannot wrap.
  always_comb begin
    x_end = {1'b0, x0} + {1'b0, w};
    y_end = {2'b0, y0} + {2'b0, h};
    xe    = (x_end > 10'(FB_W)) ? 10'(FB_W) : x_end;
    ye    = (y_end > 10'(FB_H)) ? 10'(FB_H) : y_end;
    empty = (w == 9'd0) || (h == 8'd0) ||
            ({1'b0, x0} >= 10'(FB_W)) || ({2'b0, y0} >= 10'(FB_H));
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill write engine for the VGA frame buffer: captures a command,
// clips it, optionally waits for vertical sync, then writes one pixel per ack.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int FB_W    = fb_pkg::FB_W,
  parameter int FB_H    = fb_pkg::FB_H,
  parameter int ADDR_W  = $clog2(fb_pkg::FB_PIXELS),
  parameter int COLOR_W = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [8:0]         cmd_x0,
  input  logic [7:0]         cmd_y0,
  input  logic [8:0]         cmd_w,
  input  logic [7:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               cmd_sync,
  input  logic               vs,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ack,
  output logic               busy,
  output logic               done
);

  wr_state_t  state_reg;
  wr_state_t  state_next;
  rect_cmd_t  cmd_reg;
  logic [9:0] xe_reg;
  logic [9:0] ye_reg;
  logic [8:0] x_reg;
  logic [7:0] y_reg;
  fb_addr_t   row_base_reg;
  logic       vs_prev_reg;

  logic [9:0] clip_xe;
  logic [9:0] clip_ye;
  logic       clip_empty;
  logic       capture;
  logic       beat_ack;
  logic       last_x;
  logic       last_y;
  logic       vs_fall;

  // Clip always looks at the latched command, never at the live inputs.
  fb_rect_clip #(
    .FB_W (FB_W),
    .FB_H (FB_H)
  ) u_clip (
    .x0    (cmd_reg.x0),
    .y0    (cmd_reg.y0),
    .w     (cmd_reg.w),
    .h     (cmd_reg.h),
    .xe    (clip_xe),
    .ye    (clip_ye),
    .empty (clip_empty)
  );

  // Handshake and write-progress qualifiers.
  always_comb begin
    capture  = (state_reg == IDLE) && cmd_valid;
    beat_ack = (state_reg == WRITE) && fb_ack;
    last_x   = ({1'b0, x_reg} == (xe_reg - 10'd1));
    last_y   = ({2'b0, y_reg} == (ye_reg - 10'd1));
    vs_fall  = vs_prev_reg && !vs;
  end

  // State register; reset abandons any command in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and output decode. Outputs are pure state decodes so that an
  // asynchronous reset pulls fb_we low immediately.
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_data    = '0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_next = CLIP;
        end
      end
      CLIP: begin
        if (clip_empty) begin
          state_next = DONE;
        end else if (cmd_reg.sync) begin
          state_next = WAIT_VS;
        end else begin
          state_next = WRITE;
        end
      end
      WAIT_VS: begin
        if (vs_fall) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        fb_we   = 1'b1;
        fb_addr = ADDR_W'(row_base_reg + fb_addr_t'(x_reg));
        fb_data = COLOR_W'(cmd_reg.color);
        if (fb_ack && last_x && last_y) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // vs history is tracked every cycle, so a fall seen during CLIP is already
  // consumed by the time WAIT_VS starts looking for an edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_prev_reg <= 1'b1;
    end else begin
      vs_prev_reg <= vs;
    end
  end

  // Latch the command once at capture; it is never re-sampled afterwards.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cmd_reg <= '0;
    end else if (capture) begin
      cmd_reg.x0    <= cmd_x0;
      cmd_reg.y0    <= cmd_y0;
      cmd_reg.w     <= cmd_w;
      cmd_reg.h     <= cmd_h;
      cmd_reg.color <= fb_color_t'(cmd_color);
      cmd_reg.sync  <= cmd_sync;
    end
  end

  // Raster walk: load bounds and start point in CLIP, advance on each ack.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      xe_reg       <= '0;
      ye_reg       <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      row_base_reg <= '0;
    end else if (state_reg == CLIP) begin
      xe_reg       <= clip_xe;
      ye_reg       <= clip_ye;
      x_reg        <= cmd_reg.x0;
      y_reg        <= cmd_reg.y0;
      row_base_reg <= row_base_of(cmd_reg.y0);
    end else if (beat_ack) begin
      if (!last_x) begin
        x_reg <= x_reg + 9'd1;
      end else if (!last_y) begin
        x_reg        <= cmd_reg.x0;
        y_reg        <= y_reg + 8'd1;
        row_base_reg <= row_base_reg + fb_addr_t'(FB_W);
      end
    end
  end

endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
- Write-side engine for the 320x240 pixel-doubled frame buffer that the VGA scan-out reads.
- Accepts rectangle-fill commands over a valid/ready handshake and clips each rectangle to the frame.
- Emits one frame-buffer write per accepted beat at the linear address y*320+x.
- Can optionally hold a command until the next vertical sync, so a fill does not tear against scan-out.

Parameters:
- FB_W, 320, frame-buffer width in pixels.
- FB_H, 240, frame-buffer height in lines.
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= FB_W*FB_H (76800).
- COLOR_W, 8, pixel data width.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x0  in  9  left column.
- cmd_y0  in  8  top line.
- cmd_w  in  9  width in pixels.
- cmd_h  in  8  height in lines.
- cmd_color  in  COLOR_W  fill value.
- cmd_sync  in  1  if 1, wait for the next vs falling edge before writing.
- vs  in  1  vertical sync, active low, synchronous to Clk.
- fb_we  out  1  write request.
- fb_addr  out  ADDR_W  write address.
- fb_data  out  COLOR_W  write data.
- fb_ack  in  1  write accepted this cycle; counts only when fb_we=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command has completed.

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-low on Reset_n.
- Reset values: state=IDLE, cmd_ready=1, fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0, vs_prev=1.
- While Reset_n is low, fb_we is forced to 0 immediately. A command in flight is abandoned; no resume after reset.
- Handshake: a command is captured when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE.
- FSM state IDLE: on capture, go to CLIP.
- FSM state CLIP (one cycle):
  - xe = min(x0+w, FB_W) and ye = min(y0+h, FB_H), computed 10 bits wide with no wrap.
  - The rectangle is empty if w==0, h==0, x0>=FB_W or y0>=FB_H.
  - Empty rectangle: go to DONE with zero writes.
  - Otherwise set x=x0, y=y0 and row_base=(y0<<8)+(y0<<6), i.e. y0*320 with no multiplier.
  - Next state is WAIT_VS if cmd_sync=1, else WRITE.
- FSM state WAIT_VS:
  - Sample vs every cycle into vs_prev.
  - On vs_prev=1 && vs=0, go to WRITE.
  - A falling edge that occurs during CLIP does not count.
- FSM state WRITE:
  - fb_we=1, fb_addr=row_base+x, fb_data=color.
  - fb_we, fb_addr and fb_data hold stable until fb_ack; fb_we never deasserts without an ack.
  - On ack with x<xe-1: x increments.
  - On ack with x==xe-1: x=x0, y increments and row_base increases by 320.
  - On ack with x==xe-1 and y==ye-1: go to DONE. fb_we falls the cycle after the final ack.
  - Back-to-back acks give one pixel per clock.
- FSM state DONE: done=1 for exactly one cycle, then IDLE. cmd_ready returns to 1 the cycle after done.
- Latency, with cmd_sync=0 and fb_ack tied high:
  - Command captured at edge T; CLIP at T+1; first fb_we at T+2.
  - Last write at T+1+N, where N=(xe-x0)*(ye-y0).
  - done at T+2+N.
- Write count per command is exactly the clipped area N; no write ever has x>=FB_W or y>=FB_H.
- fb_addr never exceeds FB_W*FB_H-1.
- cmd_* inputs are ignored outside IDLE; captured values are latched and never re-sampled.

Decomposition:
- Shared package fb_pkg holds:
  - constants FB_W, FB_H and FB_PIXELS=76800;
  - typedefs fb_addr_t (logic [16:0]) and fb_color_t (logic [7:0]);
  - struct rect_cmd_t {x0, y0, w, h, color, sync};
  - enum wr_state_t {IDLE, CLIP, WAIT_VS, WRITE, DONE}.
- One sub-module, fb_rect_clip, holds the combinational clip and empty check. All sequencing stays in the top.

Test Plan:
- Basic fill, fb_ack=1: x0=10, y0=5, w=3, h=2, color=0xA5, sync=0 -> six writes to addresses 1610, 1611, 1612, 1930, 1931, 1932, all with data 0xA5; done at T+8.
- Right/bottom clip: x0=318, y0=239, w=5, h=4 -> two writes, to 76798 and 76799, then done.
- Empty commands: w=0; then x0=320; then y0=240 -> no fb_we in any case; done at T+2 each time; cmd_ready stays 0 until after done.
- Backpressure: x0=0, y0=0, w=2, h=1, fb_ack low for 3 cycles on each beat -> fb_we, fb_addr and fb_data stay stable while waiting; addresses 0 then 1; exactly two writes.
- Sync wait: sync=1 with vs held high for 20 cycles, then falling -> no fb_we before the falling edge; first write one cycle after the falling edge is sampled.
- Mid-operation reset: drop Reset_n during the 4th write of a 4x4 fill -> fb_we goes 0 asynchronously; after release, busy=0 and cmd_ready=1; a new 1x1 command at 0,0 writes address 0 exactly once.
